// File: rtl/tiny_imem_loader.sv
// Serial instruction-memory loader.
// Holds the CPU in reset while bytes arrive and verifies a trailing checksum.
module tiny_imem_loader #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              ser_clk,
  input  logic              ser_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    FIN
  } state_t;

  state_t state;

  logic load_s1, load_s2;
  logic sclk_s1, sclk_s2, sclk_d;
  logic data_s1, data_s2;

  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [7:0]        csum;
  logic [7:0]        shreg;

  logic       bit_ev;
  logic [7:0] nxt_byte;

  assign bit_ev   = sclk_s2 & ~sclk_d;
  assign nxt_byte = {shreg[6:0], data_s2};

  // Two-flop synchronizers for all pins plus a delay flop for strobe edges
  always_ff @(posedge clk) begin
    if (rst) begin
      load_s1 <= 1'b0;
      load_s2 <= 1'b0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      load_s1 <= load_en;
      load_s2 <= load_s1;
      sclk_s1 <= ser_clk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      data_s1 <= ser_data;
      data_s2 <= data_s1;
    end
  end

  // Session FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      csum     <= '0;
      shreg    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_s2) begin
            state    <= RECV;
            done     <= 1'b0;
            err      <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            csum     <= '0;
            cpu_hold <= 1'b1;
          end
        end
        RECV: begin
          if (!load_s2) begin
            state    <= IDLE;
            err      <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (bit_ev) begin
            shreg   <= nxt_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state   <= WRITE;
              wr_en   <= 1'b1;
              wr_addr <= word_cnt;
              wr_data <= nxt_byte;
            end
          end
        end
        WRITE: begin
          csum <= csum + wr_data;
          if (word_cnt < LAST) begin
            word_cnt <= word_cnt + 1'b1;
          end
          if (bit_ev) begin
            shreg   <= nxt_byte;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (!load_s2) begin
            state    <= IDLE;
            err      <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (word_cnt < LAST) begin
            state <= RECV;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!load_s2) begin
            state    <= IDLE;
            err      <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (bit_ev) begin
            shreg   <= nxt_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state    <= FIN;
              cpu_hold <= 1'b0;
              if (nxt_byte == csum) begin
                done <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        FIN: begin
          if (!load_s2) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tiny_imem_loader.md
TINY_IMEM_LOADER -- requirements
Module: tiny_imem_loader

Interface
REQ-001 Parameter NUM_WORDS, default 16, number of instruction words loaded per session.
REQ-002 Parameter ADDR_W, default 4, instruction memory address width; NUM_WORDS SHALL be at most 2**ADDR_W.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_en  input  1  asynchronous session enable (pin); high opens a load session.
REQ-006 ser_clk  input  1  asynchronous serial bit strobe (pin); bit sampled on its rising edge.
REQ-007 ser_data  input  1  asynchronous serial data (pin), MSB first.
REQ-008 wr_en  output  1  one-cycle instruction memory write strobe.
REQ-009 wr_addr  output  ADDR_W  instruction memory write address.
REQ-010 wr_data  output  8  instruction word to write.
REQ-011 cpu_hold  output  1  high keeps processor in reset while loading.
REQ-012 done  output  1  sticky: last session completed with a good checksum.
REQ-013 err  output  1  sticky: last session aborted or failed its checksum.

Function
REQ-014 load_en, ser_clk, ser_data SHALL each pass through a 2-flop synchronizer; only synchronized versions are used internally.
REQ-015 Bit event = synchronized ser_clk 0->1 (compare with one extra delayed flop); synchronized ser_data SHALL be shifted into an 8-bit register LSB-ward (MSB first) on that cycle.
REQ-016 States: IDLE, RECV, WRITE, CHECK, FIN.
REQ-017 IDLE -> RECV when synchronized load_en is 1; on that transition clear done, err, bit count, word count, checksum.
REQ-018 RECV: on the 8th bit event -> WRITE next cycle, bit count wraps to 0.
REQ-019 WRITE (exactly one cycle): wr_en=1, wr_addr=word count, wr_data=assembled byte; checksum += byte mod 256; word count +1.
REQ-020 WRITE -> RECV if word count before increment < NUM_WORDS-1, else -> CHECK.
REQ-021 CHECK: receive 8 further bits as checksum byte, no write; on 8th bit -> FIN; set done if byte equals accumulated checksum, else set err.
REQ-022 FIN -> IDLE when synchronized load_en is 0; word count never wraps past NUM_WORDS-1 within a session.
REQ-023 Abort: synchronized load_en 0 in RECV, WRITE or CHECK -> IDLE next cycle, err=1, no further wr_en; a pending WRITE cycle still completes if already entered.
REQ-024 wr_en SHALL be 0 in every state except WRITE; wr_addr/wr_data hold last written values otherwise.
REQ-025 cpu_hold = 1 in RECV, WRITE, CHECK; 0 in IDLE and FIN.
REQ-026 Bit events in IDLE and FIN SHALL be ignored; bit events in the WRITE cycle SHALL be accepted as bit 0 of the next byte.
REQ-027 ser_clk edges closer than 4 clk cycles are outside spec; no requirement.

Reset
REQ-028 rst SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, counters, checksum, shift register and synchronizer flops to 0.
REQ-029 rst asserted mid-session SHALL abandon it without setting err; first output change after release no earlier than 3 cycles (synchronizer latency).

Verification
REQ-030 Full load: 44 0F 1E 22 1F 0E F2 13 then eight 00, checksum C5 -> 16 wr_en pulses at addr 0..15 with those bytes, done=1, err=0, cpu_hold falls on entering FIN.
REQ-031 Bad checksum: same 16 bytes, checksum C4 -> all 16 writes occur, err=1, done=0.
REQ-032 Abort: drop load_en after 5 bytes -> exactly 5 writes (addr 0..4), err=1, cpu_hold=0 within 3 cycles after drop.
REQ-033 New session after error: reassert load_en -> err and done clear on entry to RECV, first write at addr 0.
REQ-034 rst after 3 bytes -> all outputs 0, no further wr_en, err=0.
REQ-035 Edge spacing: ser_clk period of exactly 4 clk cycles and bit event coinciding with WRITE -> no lost bits, byte values exact.
